// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with an IDLE/ACCESS data-memory FSM.
// Ports: clk, rst (sync, active-high); EX/MEM inputs instr_in, pc_in,
//   alu_out_in, rdata2_in, rd_in, opcode_in, valid_in; stall_out upstream;
//   dmem_req/we/addr/wdata/be out, dmem_rdata/ack in; registered MEM/WB
//   outputs wb_instr/pc/result/rd/regwrite/valid_out, misalign_out,
//   timeout_out.
// Parameter ACK_TIMEOUT (2..255): ACCESS cycles without ack before abort.
// Macro SUBWORD_ACCESS_EN: enables byte/half lanes; otherwise every
//   memory op behaves as a word access.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] rdata2_in,
    input  logic [4:0]  rd_in,
    input  logic [5:0]  opcode_in,
    input  logic        valid_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] wb_instr_out,
    output logic [31:0] wb_pc_out,
    output logic [31:0] wb_result_out,
    output logic [4:0]  wb_rd_out,
    output logic        wb_regwrite_out,
    output logic        wb_valid_out,
    output logic        misalign_out,
    output logic        timeout_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] cap_instr, cap_pc, cap_addr, cap_data;
    logic [4:0]  cap_rd;
    logic        cap_store;

    logic        dec_mem, dec_store, mis, tmo;
    logic [3:0]  be_w;
    logic [31:0] wdata_w, ld_data;

`ifdef SUBWORD_ACCESS_EN
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic [1:0] dec_size, cap_size;
    logic       dec_uns, cap_uns;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
`endif

    always_comb begin
        dec_mem   = 1'b1;
        dec_store = 1'b0;
`ifdef SUBWORD_ACCESS_EN
        dec_size  = SZ_W;
        dec_uns   = 1'b0;
`endif
        unique case (opcode_in)
            6'h23: ;
            6'h2B: dec_store = 1'b1;
`ifdef SUBWORD_ACCESS_EN
            6'h20: dec_size = SZ_B;
            6'h24: begin dec_size = SZ_B; dec_uns = 1'b1; end
            6'h21: dec_size = SZ_H;
            6'h25: begin dec_size = SZ_H; dec_uns = 1'b1; end
            6'h28: begin dec_size = SZ_B; dec_store = 1'b1; end
            6'h29: begin dec_size = SZ_H; dec_store = 1'b1; end
`else
            6'h20, 6'h24, 6'h21, 6'h25: ;
            6'h28, 6'h29: dec_store = 1'b1;
`endif
            default: dec_mem = 1'b0;
        endcase
    end

`ifdef SUBWORD_ACCESS_EN
    always_comb begin
        unique case (dec_size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = alu_out_in[0];
            default: mis = (alu_out_in[1:0] != 2'b00);
        endcase
    end

    // Little-endian lanes: byte k lives in bits 8k+7:8k.
    always_comb begin
        be_w    = 4'b1111;
        wdata_w = cap_data;
        ld_data = dmem_rdata;
        lane_b  = 8'(dmem_rdata >> {cap_addr[1:0], 3'b000});
        lane_h  = 16'(dmem_rdata >> {cap_addr[1], 4'b0000});
        unique case (cap_size)
            SZ_B: begin
                be_w    = 4'b0001 << cap_addr[1:0];
                wdata_w = {4{cap_data[7:0]}};
                ld_data = cap_uns ? {24'b0, lane_b}
                                  : {{24{lane_b[7]}}, lane_b};
            end
            SZ_H: begin
                be_w    = cap_addr[1] ? 4'b1100 : 4'b0011;
                wdata_w = {2{cap_data[15:0]}};
                ld_data = cap_uns ? {16'b0, lane_h}
                                  : {{16{lane_h[15]}}, lane_h};
            end
            default: ;
        endcase
    end
`else
    assign mis     = (alu_out_in[1:0] != 2'b00);
    assign be_w    = 4'b1111;
    assign wdata_w = cap_data;
    assign ld_data = dmem_rdata;
`endif

    // Ack wins over a timeout landing in the same cycle.
    assign tmo = (state == ACCESS) && !dmem_ack && (cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        stall_out  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        dmem_addr  = 32'b0;
        dmem_wdata = 32'b0;
        unique case (state)
            IDLE: begin
                if (valid_in && dec_mem && !mis) begin
                    stall_out = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = cap_store;
                dmem_be    = be_w;
                dmem_addr  = cap_addr & 32'hFFFF_FFFC;
                dmem_wdata = wdata_w;
                // The slot retires on ack or timeout, so upstream may move.
                if (dmem_ack || tmo) state_nxt = IDLE;
                else                 stall_out = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= 8'd0;
            cap_instr       <= 32'b0;
            cap_pc          <= 32'b0;
            cap_addr        <= 32'b0;
            cap_data        <= 32'b0;
            cap_rd          <= 5'd0;
            cap_store       <= 1'b0;
`ifdef SUBWORD_ACCESS_EN
            cap_size        <= SZ_W;
            cap_uns         <= 1'b0;
`endif
            wb_instr_out    <= 32'b0;
            wb_pc_out       <= 32'b0;
            wb_result_out   <= 32'b0;
            wb_rd_out       <= 5'd0;
            wb_regwrite_out <= 1'b0;
            wb_valid_out    <= 1'b0;
            misalign_out    <= 1'b0;
            timeout_out     <= 1'b0;
        end else begin
            misalign_out <= 1'b0;
            timeout_out  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!valid_in) begin
                        wb_valid_out    <= 1'b0;
                        wb_regwrite_out <= 1'b0;
                    end else if (!dec_mem) begin
                        wb_instr_out    <= instr_in;
                        wb_pc_out       <= pc_in;
                        wb_result_out   <= alu_out_in;
                        wb_rd_out       <= rd_in;
                        wb_regwrite_out <= (rd_in != 5'd0) &&
                                           (opcode_in != 6'h02) &&
                                           (opcode_in != 6'h04) &&
                                           (opcode_in != 6'h05);
                        wb_valid_out    <= 1'b1;
                    end else if (mis) begin
                        wb_instr_out    <= instr_in;
                        wb_pc_out       <= pc_in;
                        wb_result_out   <= alu_out_in;
                        wb_rd_out       <= rd_in;
                        wb_regwrite_out <= 1'b0;
                        wb_valid_out    <= 1'b1;
                        misalign_out    <= 1'b1;
                    end else begin
                        cnt             <= 8'd0;
                        cap_instr       <= instr_in;
                        cap_pc          <= pc_in;
                        cap_addr        <= alu_out_in;
                        cap_data        <= rdata2_in;
                        cap_rd          <= rd_in;
                        cap_store       <= dec_store;
`ifdef SUBWORD_ACCESS_EN
                        cap_size        <= dec_size;
                        cap_uns         <= dec_uns;
`endif
                        wb_valid_out    <= 1'b0;
                        wb_regwrite_out <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack || tmo) begin
                        wb_instr_out    <= cap_instr;
                        wb_pc_out       <= cap_pc;
                        wb_rd_out       <= cap_rd;
                        wb_valid_out    <= 1'b1;
                        wb_regwrite_out <= dmem_ack && !cap_store &&
                                           (cap_rd != 5'd0);
                        if (dmem_ack) wb_result_out <= ld_data;
                        else          timeout_out   <= 1'b1;
                    end else begin
                        cnt             <= cnt + 8'd1;
                        wb_valid_out    <= 1'b0;
                        wb_regwrite_out <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
// Expected MEM/WB results are queued at issue and popped on wb_valid_out.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in, pc_in, alu_out_in, rdata2_in;
    logic [4:0]  rd_in;
    logic [5:0]  opcode_in;
    logic        valid_in;
    logic        stall_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] wb_instr_out, wb_pc_out, wb_result_out;
    logic [4:0]  wb_rd_out;
    logic        wb_regwrite_out, wb_valid_out, misalign_out, timeout_out;

    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .instr_in(instr_in), .pc_in(pc_in),
        .alu_out_in(alu_out_in), .rdata2_in(rdata2_in),
        .rd_in(rd_in), .opcode_in(opcode_in), .valid_in(valid_in),
        .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_instr_out(wb_instr_out), .wb_pc_out(wb_pc_out),
        .wb_result_out(wb_result_out), .wb_rd_out(wb_rd_out),
        .wb_regwrite_out(wb_regwrite_out), .wb_valid_out(wb_valid_out),
        .misalign_out(misalign_out), .timeout_out(timeout_out)
    );

    typedef struct {
        logic [31:0] instr, pc, result;
        logic [4:0]  rd;
        logic        regwrite, misalign, timeout, chk_res;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   pcv     = 0;
    int   st, rq;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_be;
    logic        a_we;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (wb_valid_out === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid_out), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("wb_instr", wb_instr_out, e.instr);
                chk("wb_pc", wb_pc_out, e.pc);
                chk("wb_rd", 32'(wb_rd_out), 32'(e.rd));
                chk("wb_regwrite", 32'(wb_regwrite_out), 32'(e.regwrite));
                chk("misalign", 32'(misalign_out), 32'(e.misalign));
                chk("timeout", 32'(timeout_out), 32'(e.timeout));
                if (e.chk_res) chk("wb_result", wb_result_out, e.result);
            end
        end
    end

    task automatic issue(logic [5:0] op, logic [31:0] addr,
                         logic [31:0] data, logic [4:0] rd);
        instr_in   = {op, 5'd0, rd, 16'(pcv)};
        pc_in      = 32'h1000 + 32'(pcv) * 32'd4;
        pcv++;
        opcode_in  = op;
        alu_out_in = addr;
        rdata2_in  = data;
        rd_in      = rd;
        valid_in   = 1'b1;
    endtask

    task automatic push(logic [31:0] res, logic rw, logic mis,
                        logic tmo, logic cr);
        exp_t x;
        x.instr = instr_in; x.pc = pc_in; x.rd = rd_in;
        x.result = res; x.regwrite = rw; x.misalign = mis;
        x.timeout = tmo; x.chk_res = cr;
        sbq.push_back(x);
    endtask

    // Runs from the issue cycle (c=0) through ACCESS; ack_at < 0 = no ack.
    task automatic mem_op(int ack_at, logic [31:0] rdata,
                          output int stalls, output int reqs,
                          output logic [31:0] o_addr, output logic [31:0] o_wd,
                          output logic [3:0] o_be, output logic o_we);
        stalls = 0; reqs = 0;
        o_addr = '0; o_wd = '0; o_be = '0; o_we = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            #1;
            if (stall_out) stalls++;
            if (dmem_req) begin
                reqs++;
                o_addr = dmem_addr; o_wd = dmem_wdata;
                o_be = dmem_be; o_we = dmem_we;
            end
            if (c > 0 && !dmem_req) break;
            @(negedge clk);
            dmem_ack = 1'b0;
            valid_in = 1'b0;
            if (c == ack_at) break;
        end
    endtask

    task automatic misop(logic [5:0] op, logic [31:0] addr, logic [4:0] rd);
        issue(op, addr, 32'h0, rd);
        push(addr, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("mis_stall", 32'(stall_out), 32'd0);
        chk("mis_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        chk("mis_pulse_end", 32'(misalign_out), 32'd0);
    endtask

    task automatic st_op(logic [5:0] op, logic [31:0] addr, logic [31:0] d,
                         logic [3:0] xbe, logic [31:0] xwd);
        issue(op, addr, d, 5'd0);
        push(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_op(1, 32'h0, st, rq, a_addr, a_wdata, a_be, a_we);
        chk("st_addr", a_addr, addr & 32'hFFFF_FFFC);
        chk("st_be", 32'(a_be), 32'(xbe));
        chk("st_wdata", a_wdata, xwd);
        chk("st_we", 32'(a_we), 32'd1);
    endtask

    task automatic ld_op(logic [5:0] op, logic [31:0] addr,
                         logic [31:0] rdata, logic [31:0] xres);
        issue(op, addr, 32'h0, 5'd4);
        push(xres, 1'b1, 1'b0, 1'b0, 1'b1);
        mem_op(2, rdata, st, rq, a_addr, a_wdata, a_be, a_we);
        chk("ld_we", 32'(a_we), 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; dmem_ack = 1'b0;
        instr_in = '0; pc_in = '0; alu_out_in = '0; rdata2_in = '0;
        rd_in = '0; opcode_in = '0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid_out), 32'd0);
        chk("rst_wb_regwrite", 32'(wb_regwrite_out), 32'd0);
        chk("rst_wb_result", wb_result_out, 32'd0);
        chk("rst_wb_instr", wb_instr_out, 32'd0);
        chk("rst_misalign", 32'(misalign_out), 32'd0);
        chk("rst_timeout", 32'(timeout_out), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        rst = 1'b0;

        issue(6'h00, 32'h1234, 32'h0, 5'd5);
        push(32'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 chk("alu_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        issue(6'h04, 32'h55, 32'h0, 5'd3);
        push(32'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        issue(6'h0D, 32'h66, 32'h0, 5'd0);
        push(32'h66, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        issue(6'h08, 32'hFFFF_FFFF, 32'h0, 5'd31);
        push(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        chk("bubble_valid", 32'(wb_valid_out), 32'd0);
        chk("bubble_regwrite", 32'(wb_regwrite_out), 32'd0);
        chk("bubble_hold", wb_result_out, 32'hFFFF_FFFF);

        issue(6'h23, 32'h100, 32'h0, 5'd7);
        push(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        mem_op(3, 32'hDEAD_BEEF, st, rq, a_addr, a_wdata, a_be, a_we);
        chk("lw_stalls", 32'(st), 32'd3);
        chk("lw_reqs", 32'(rq), 32'd3);
        chk("lw_addr", a_addr, 32'h100);
        chk("lw_be", 32'(a_be), 32'hF);
        chk("lw_we", 32'(a_we), 32'd0);

        st_op(6'h2B, 32'h104, 32'h1122_3344, 4'b1111, 32'h1122_3344);
        chk("sw_stalls", 32'(st), 32'd1);

        issue(6'h23, 32'h300, 32'h0, 5'd9);
        push(32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b1);
        mem_op(TO, 32'hCAFE_F00D, st, rq, a_addr, a_wdata, a_be, a_we);
        chk("ackprio_reqs", 32'(rq), 32'(TO));

`ifdef SUBWORD_ACCESS_EN
        st_op(6'h28, 32'h103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        st_op(6'h29, 32'h102, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        ld_op(6'h20, 32'h103, 32'h8000_0000, 32'hFFFF_FF80);
        ld_op(6'h24, 32'h103, 32'h8000_0000, 32'h0000_0080);
        ld_op(6'h20, 32'h100, 32'h8001_7F7F, 32'h0000_007F);
        ld_op(6'h21, 32'h102, 32'h8001_7F00, 32'hFFFF_8001);
        ld_op(6'h25, 32'h102, 32'h8001_7F00, 32'h0000_8001);
        misop(6'h21, 32'h101, 5'd6);
`else
        misop(6'h28, 32'h103, 5'd0);
        misop(6'h20, 32'h103, 5'd4);
        ld_op(6'h24, 32'h100, 32'h8000_0000, 32'h8000_0000);
        chk("lbu_word_be", 32'(a_be), 32'hF);
        st_op(6'h29, 32'h108, 32'h0000_BEEF, 4'b1111, 32'h0000_BEEF);
`endif
        misop(6'h23, 32'h102, 5'd2);

        issue(6'h23, 32'h200, 32'h0, 5'd8);
        push(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        mem_op(-1, 32'h0, st, rq, a_addr, a_wdata, a_be, a_we);
        chk("tmo_reqs", 32'(rq), 32'(TO));
        chk("tmo_stalls", 32'(st), 32'(TO));
        @(negedge clk);
        chk("tmo_pulse_end", 32'(timeout_out), 32'd0);
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_valid", 32'(wb_valid_out), 32'd0);
        chk("idle_ack_req", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;

        issue(6'h23, 32'h400, 32'h0, 5'd10);
        @(negedge clk);
        valid_in = 1'b0;
        #1 chk("rsta_req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        #1;
        chk("rsta_wb_valid", 32'(wb_valid_out), 32'd0);
        chk("rsta_wb_result", wb_result_out, 32'd0);
        chk("rsta_wb_rd", 32'(wb_rd_out), 32'd0);
        chk("rsta_stall", 32'(stall_out), 32'd0);
        chk("rsta_req", 32'(dmem_req), 32'd0);
        chk("rsta_be", 32'(dmem_be), 32'd0);
        chk("rsta_we", 32'(dmem_we), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late_ack_valid", 32'(wb_valid_out), 32'd0);
        chk("late_ack_result", wb_result_out, 32'd0);
        @(negedge clk);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
